// File: rtl/pcpu_mem.sv
// Dual-memory subsystem for a small CPU: instruction and data memories with
// combinational CPU reads, a host access port, and a dmem zero-fill engine.
module pcpu_mem #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_active,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_datain,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dataout,
  input  logic          d_we,
  output logic [DW-1:0] d_datain,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic          h_sel,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  input  logic          clr_req,
  output logic          clr_done,
  output logic          err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    CLEAR
  } state_t;

  state_t        state;
  logic [AW-1:0] counter;

  logic [DW-1:0] imem [DEPTH];
  logic [DW-1:0] dmem [DEPTH];

  logic host_accept;
  logic host_iwe;
  logic host_dwe;
  logic clear_we;
  logic cpu_we;

  assign i_datain = imem[i_addr];
  assign d_datain = dmem[d_addr];

  assign h_ready     = (state == IDLE) && !cpu_active && !clr_req;
  assign host_accept = h_valid && h_ready;
  assign host_iwe    = host_accept && h_we && !h_sel;
  assign host_dwe    = host_accept && h_we && h_sel;
  assign clear_we    = (state == CLEAR);
  // CPU stores are blocked for the whole fill so the cleared image stays clean.
  assign cpu_we      = d_we && cpu_active && (state != CLEAR);

  // Array contents are never reset; the write sources are mutually exclusive
  // by construction, the priority order only documents intent.
  always_ff @(posedge clock) begin
    if (host_iwe) begin
      imem[h_addr] <= h_wdata;
    end
    if (clear_we) begin
      dmem[counter] <= '0;
    end else if (host_dwe) begin
      dmem[h_addr] <= h_wdata;
    end else if (cpu_we) begin
      dmem[d_addr] <= d_dataout;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      counter  <= '0;
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
      clr_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      h_rvalid <= 1'b0;
      clr_done <= 1'b0;
      if (clear_we && d_we && cpu_active) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (clr_req && !cpu_active) begin
            state   <= CLEAR;
            counter <= '0;
          end else if (host_accept && !h_we) begin
            h_rdata  <= h_sel ? dmem[h_addr] : imem[h_addr];
            h_rvalid <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        CLEAR: begin
          counter <= counter + 1'b1;
          if (counter == LAST_ADDR) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpu_mem.sv
// Directed self-checking bench for pcpu_mem: host/CPU access, zero-fill,
// conflict flag and reset behaviour.
module tb_pcpu_mem;

  logic        clock;
  logic        reset;
  logic        cpu_active;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        h_valid;
  logic        h_ready;
  logic        h_sel;
  logic        h_we;
  logic [7:0]  h_addr;
  logic [15:0] h_wdata;
  logic [15:0] h_rdata;
  logic        h_rvalid;
  logic        clr_req;
  logic        clr_done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  pcpu_mem #(.AW(8), .DW(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_active(cpu_active),
    .i_addr    (i_addr),
    .i_datain  (i_datain),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_we      (d_we),
    .d_datain  (d_datain),
    .h_valid   (h_valid),
    .h_ready   (h_ready),
    .h_sel     (h_sel),
    .h_we      (h_we),
    .h_addr    (h_addr),
    .h_wdata   (h_wdata),
    .h_rdata   (h_rdata),
    .h_rvalid  (h_rvalid),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic sel, input logic [7:0] addr, input logic [15:0] data);
    h_valid = 1'b1; h_we = 1'b1; h_sel = sel; h_addr = addr; h_wdata = data;
    step();
    h_valid = 1'b0; h_we = 1'b0;
  endtask

  task automatic dmem_peek(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    d_addr = addr;
    #1;
    check(tag, {16'h0, d_datain}, {16'h0, exp});
  endtask

  initial begin
    reset = 1'b0; cpu_active = 1'b0; i_addr = '0; d_addr = '0; d_dataout = '0;
    d_we = 1'b0; h_valid = 1'b0; h_sel = 1'b0; h_we = 1'b0; h_addr = '0;
    h_wdata = '0; clr_req = 1'b0;

    #3;
    check("rst_h_ready",  {31'h0, h_ready},  32'h1);
    check("rst_h_rvalid", {31'h0, h_rvalid}, 32'h0);
    check("rst_h_rdata",  {16'h0, h_rdata},  32'h0);
    check("rst_clr_done", {31'h0, clr_done}, 32'h0);
    check("rst_err",      {31'h0, err},      32'h0);
    step();
    reset = 1'b1;

    // Host imem write, visible to the fetch port after the edge
    host_write(1'b0, 8'h05, 16'h4A21);
    i_addr = 8'h05;
    #1;
    check("imem_fetch", {16'h0, i_datain}, 32'h4A21);

    // Host dmem write then 1-cycle read
    host_write(1'b1, 8'h10, 16'hBEEF);
    h_valid = 1'b1; h_we = 1'b0; h_sel = 1'b1; h_addr = 8'h10;
    step();
    h_valid = 1'b0;
    #1;
    check("rd_rvalid",   {31'h0, h_rvalid}, 32'h1);
    check("rd_rdata",    {16'h0, h_rdata},  32'hBEEF);
    check("rd_ready_resp", {31'h0, h_ready}, 32'h0);
    step();
    check("rd_rvalid_end", {31'h0, h_rvalid}, 32'h0);
    check("rd_rdata_hold", {16'h0, h_rdata},  32'hBEEF);
    check("rd_ready_idle", {31'h0, h_ready},  32'h1);

    // Host read of imem
    h_valid = 1'b1; h_sel = 1'b0; h_addr = 8'h05;
    step();
    h_valid = 1'b0;
    check("rd_imem", {16'h0, h_rdata}, 32'h4A21);
    step();

    // CPU store while active; a pending host request is held off
    cpu_active = 1'b1; d_we = 1'b1; d_addr = 8'h22; d_dataout = 16'h1234;
    h_valid = 1'b1; h_sel = 1'b1; h_addr = 8'h10;
    #1;
    check("holdoff_ready", {31'h0, h_ready}, 32'h0);
    step();
    d_we = 1'b0;
    #1;
    check("cpu_store",      {16'h0, d_datain}, 32'h1234);
    check("holdoff_rvalid", {31'h0, h_rvalid}, 32'h0);
    check("holdoff_err",    {31'h0, err},      32'h0);
    h_valid = 1'b0; cpu_active = 1'b0;
    step();

    // CPU store with cpu_active low is ignored
    host_write(1'b1, 8'h23, 16'h0007);
    d_we = 1'b1; d_addr = 8'h23; d_dataout = 16'h9999;
    step();
    d_we = 1'b0;
    dmem_peek("cpu_store_gated", 8'h23, 16'h0007);

    // Full zero-fill
    host_write(1'b1, 8'h00, 16'h0001);
    host_write(1'b1, 8'hFF, 16'h0002);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cyc = 0;
    while (clr_done !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
      if (cyc == 1) check("clr_ready", {31'h0, h_ready}, 32'h0);
    end
    check("clr_cycles", cyc, 256);
    step();
    check("clr_done_pulse", {31'h0, clr_done}, 32'h0);
    dmem_peek("clr_word00", 8'h00, 16'h0000);
    dmem_peek("clr_wordFF", 8'hFF, 16'h0000);
    check("clr_err", {31'h0, err}, 32'h0);

    // CPU store during fill is dropped and flags err
    host_write(1'b1, 8'h80, 16'h7777);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cpu_active = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_dataout = 16'h5555;
    cyc = 0;
    while (clr_done !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    d_we = 1'b0;
    check("conf_cycles", cyc, 256);
    dmem_peek("conf_word80", 8'h80, 16'h0000);
    check("conf_err", {31'h0, err}, 32'h1);
    cpu_active = 1'b0;
    step();
    step();
    check("err_sticky", {31'h0, err}, 32'h1);

    // Reset mid-fill at counter 0x40
    host_write(1'b1, 8'h3F, 16'hAAAA);
    host_write(1'b1, 8'h40, 16'hBBBB);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (64) step();
    reset = 1'b0;
    #1;
    check("abort_err",   {31'h0, err},      32'h0);
    check("abort_ready", {31'h0, h_ready},  32'h1);
    step();
    reset = 1'b1;
    cyc = 0;
    repeat (300) begin
      step();
      if (clr_done === 1'b1) cyc++;
    end
    check("abort_no_done", cyc, 0);
    dmem_peek("abort_word3F", 8'h3F, 16'h0000);
    dmem_peek("abort_word40", 8'h40, 16'hBBBB);

    // Reset during RESP suppresses the response
    h_valid = 1'b1; h_we = 1'b0; h_sel = 1'b1; h_addr = 8'h40;
    step();
    h_valid = 1'b0;
    check("resp_rvalid", {31'h0, h_rvalid}, 32'h1);
    reset = 1'b0;
    #1;
    check("resp_rst_rvalid", {31'h0, h_rvalid}, 32'h0);
    check("resp_rst_rdata",  {16'h0, h_rdata},  32'h0);
    step();
    reset = 1'b1;
    step();
    check("resp_after_rvalid", {31'h0, h_rvalid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpu_mem.md
PCPU_MEM -- requirements
Module: pcpu_mem

Interface
REQ-001 Parameter AW, default 8, address width of both memories (depth 2^AW words).
REQ-002 Parameter DW, default 16, word width of both memories.
REQ-003 clock  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_active  in  1  high while the CPU is executing; gates the CPU write path and host access.
REQ-006 i_addr  in  AW  instruction fetch address from the CPU.
REQ-007 i_datain  out  DW  instruction word to the CPU, i.e. imem[i_addr].
REQ-008 d_addr  in  AW  CPU data address.
REQ-009 d_dataout  in  DW  CPU store data.
REQ-010 d_we  in  1  CPU data write enable.
REQ-011 d_datain  out  DW  load data to the CPU, i.e. dmem[d_addr].
REQ-012 h_valid  in  1  host request valid.
REQ-013 h_ready  out  1  host request accept.
REQ-014 h_sel  in  1  target memory: 0 = imem, 1 = dmem.
REQ-015 h_we  in  1  host access type: 1 = write, 0 = read.
REQ-016 h_addr  in  AW  host word address.
REQ-017 h_wdata  in  DW  host write data.
REQ-018 h_rdata  out  DW  host read data.
REQ-019 h_rvalid  out  1  one-cycle pulse qualifying h_rdata.
REQ-020 clr_req  in  1  request to zero-fill all of dmem.
REQ-021 clr_done  out  1  one-cycle pulse when the zero-fill completes.
REQ-022 err  out  1  sticky conflict flag.

Function
REQ-023 The block SHALL contain imem and dmem, each 2^AW x DW, with no reset applied to the array contents.
REQ-024 i_datain and d_datain SHALL be asynchronous (combinational) reads with zero-cycle latency.
REQ-025 The CPU write SHALL occur at posedge as dmem[d_addr] <= d_dataout, only when d_we=1, cpu_active=1 and the state is not CLEAR; a held d_we SHALL rewrite the same word harmlessly.
REQ-026 The FSM SHALL have three states: IDLE, RESP, CLEAR; the reset state is IDLE.
REQ-027 h_ready SHALL equal 1 only when the state is IDLE, cpu_active=0 and clr_req=0.
REQ-028 A host transfer SHALL be accepted on a posedge where h_valid=1 and h_ready=1; h_sel, h_we, h_addr and h_wdata are sampled on that edge.
REQ-029 An accepted write SHALL update the selected memory on the accepting edge, and the state SHALL remain IDLE.
REQ-030 An accepted read SHALL register the selected word into h_rdata and move the state to RESP.
REQ-031 In RESP, h_rvalid SHALL be 1 for exactly one cycle, followed by a return to IDLE; read latency is therefore 1 cycle, with one read per 2 cycles.
REQ-032 h_rdata SHALL hold its value until the next accepted read.
REQ-033 In IDLE with clr_req=1 and cpu_active=0, the block SHALL enter CLEAR with counter=0; clr_req takes priority over a simultaneous h_valid.
REQ-034 In CLEAR, the block SHALL write dmem[counter] <= 0 each cycle and increment counter; the counter wraps from 2^AW-1 to 0.
REQ-035 The cycle that writes word 2^AW-1 SHALL be the last CLEAR cycle; clr_done SHALL pulse on the following cycle together with the return to IDLE.
REQ-036 Total CLEAR duration SHALL be 2^AW cycles.
REQ-037 clr_req SHALL be level-sensitive; if it is still high in IDLE after completion, a new CLEAR starts.
REQ-038 If d_we=1 and cpu_active=1 occur during CLEAR, the CPU write SHALL be dropped, err SHALL set, and CLEAR SHALL continue.
REQ-039 If cpu_active=1 while h_valid=1 in IDLE, the request SHALL be held off via h_ready=0; err SHALL NOT set.
REQ-040 Host imem writes SHALL be visible on i_datain in the cycle after the write edge.

Reset
REQ-041 On reset=0, immediately and asynchronously: state=IDLE, counter=0, h_rdata=0, h_rvalid=0, clr_done=0, err=0, and h_ready follows REQ-027.
REQ-042 Reset during CLEAR SHALL abort it with no clr_done pulse; words already zeroed stay zeroed and the rest are unchanged.
REQ-043 Reset during RESP SHALL suppress the h_rvalid pulse.
REQ-044 err SHALL clear only on reset.

Verification
REQ-045 cpu_active=0; host write imem[0x05]=0x4A21, then i_addr=0x05 -> i_datain=0x4A21 on the next cycle.
REQ-046 Host write dmem[0x10]=0xBEEF, then host read of dmem[0x10] -> h_rvalid pulses one cycle after accept with h_rdata=0xBEEF, and h_ready=0 during RESP.
REQ-047 cpu_active=1, d_we=1, d_addr=0x22, d_dataout=0x1234 -> d_datain=0x1234 at d_addr=0x22; the same stimulus with cpu_active=0 -> no write.
REQ-048 Preload dmem[0x00]=1 and dmem[0xFF]=2, pulse clr_req -> clr_done exactly 256 cycles after entering CLEAR, both words read 0, err=0.
REQ-049 During CLEAR, cpu_active=1 with d_we=1 to address 0x80 holding 0x5555 -> the word reads 0 after completion, and err=1 sticky.
REQ-050 Assert reset at CLEAR counter=0x40 -> no clr_done; dmem[0x3F]=0 and dmem[0x40] keeps its prior value.
